// File: rtl/experiment2_switch_pkg.sv
// Shared register map, reset constants and sizing helper
// for the switch/key controller.
package experiment2_switch_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam logic [31:0] CTRL_RESET = 32'h1;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/experiment2_switch_debounce_bit.sv
// One-bit debouncer: accepts a new level after STABLE_SAMPLES
// differing ticks. SWITCH_CTRL_BOTH_EDGES_EN makes edge_o fire on falls too.
module experiment2_switch_debounce_bit
  import experiment2_switch_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic enable,
  input  logic sync_i,
  output logic deb_o,
  output logic edge_o
);

  localparam int CW = clog2(STABLE_SAMPLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_SAMPLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  logic          edge_q, edge_d;

  // Next debounced level, sample counter and change pulse
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (!enable) begin
      deb_d = sync_i;
      cnt_d = '0;
    end else if (tick) begin
      if (sync_i == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_d = ~deb_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`ifdef SWITCH_CTRL_BOTH_EDGES_EN
    edge_d = deb_d ^ deb_q;
`else
    edge_d = deb_d & ~deb_q;
`endif
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      edge_q <= edge_d;
    end
  end

  assign deb_o  = deb_q;
  assign edge_o = edge_q;

endmodule

// File: rtl/experiment2_switch_ctrl.sv
// Avalon-MM switch/key controller: sync, debounce, edge capture, irq.
// Optional macro SWITCH_CTRL_BOTH_EDGES_EN captures falling edges as well.
module experiment2_switch_ctrl
  import experiment2_switch_pkg::*;
#(
  parameter int WIDTH          = 17,
  parameter int SAMPLE_DIV     = 50000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int PW = clog2(SAMPLE_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SAMPLE_DIV - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic             ctrl_q, ctrl_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] deb, edge_pulse;
  logic             tick, wr;

  // Avalon read strobe is not needed: readdata refreshes every cycle.
  logic unused_ok;
  assign unused_ok = &{1'b0, read, writedata};

  assign tick = (presc_q == PRESC_MAX);
  assign wr   = chipselect & write;

  // Two-flop synchroniser for the raw switch levels
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      experiment2_switch_debounce_bit #(
        .STABLE_SAMPLES(STABLE_SAMPLES)
      ) u_deb (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .enable(ctrl_q),
        .sync_i(sync2_q[gi]),
        .deb_o (deb[gi]),
        .edge_o(edge_pulse[gi])
      );
    end
  endgenerate

  // Prescaler, register writes, capture and read mux
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    mask_d  = mask_q;
    ctrl_d  = ctrl_q;
    edge_d  = edge_q;
    if (wr) begin
      unique case (address)
        ADDR_MASK: mask_d = writedata[WIDTH-1:0];
        ADDR_EDGE: edge_d = edge_q & ~writedata[WIDTH-1:0];
        ADDR_CTRL: ctrl_d = writedata[0];
        default:   ;
      endcase
    end
    edge_d = edge_d | edge_pulse;

    readdata_d = '0;
    unique case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = deb;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
      default:   readdata_d[0]         = ctrl_q;
    endcase
  end

  // Register state
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      ctrl_q     <= CTRL_RESET[0];
      readdata_q <= '0;
    end else begin
      presc_q    <= presc_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      ctrl_q     <= ctrl_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_experiment2_switch_ctrl.sv
// Scoreboard bench for experiment2_switch_ctrl
// (SAMPLE_DIV=4, STABLE_SAMPLES=4).
module tb_experiment2_switch_ctrl;

  localparam int W = 17;

`ifdef SWITCH_CTRL_BOTH_EDGES_EN
  localparam logic [31:0] REL_EDGE = 32'h8;
  localparam logic        REL_IRQ  = 1'b1;
`else
  localparam logic [31:0] REL_EDGE = 32'h0;
  localparam logic        REL_IRQ  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = '0;
  logic          irq;

  typedef struct {
    logic [31:0] data;
    logic        irq;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic rd_v = 1'b0;

  experiment2_switch_ctrl #(
    .WIDTH(W), .SAMPLE_DIV(4), .STABLE_SAMPLES(4)
  ) dut (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_v <= chipselect & read;

  // Monitor: each accepted read returns data one cycle later
  always @(negedge clk) begin
    exp_t e;
    if (rd_v) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_empty: readdata=%h with no expectation", readdata);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (readdata !== e.data) begin
          n_err++;
          $display("FAIL %s: readdata=%h expected %h", e.name, readdata, e.data);
        end
        n_cmp++;
        if (irq !== e.irq) begin
          n_err++;
          $display("FAIL %s_irq: irq=%b expected %b", e.name, irq, e.irq);
        end
      end
    end
  end

  task automatic do_read(input logic [1:0] a, input logic [31:0] d,
                         input logic ie, input string nm);
    exp_t e;
    e.data = d;
    e.irq = ie;
    e.name = nm;
    sb.push_back(e);
    address = a;
    chipselect = 1'b1;
    read = 1'b1;
    write = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    read = 1'b0;
    write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0;
    read = 1'b0;
    write = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    do_read(0, 32'h0, 1'b0, "rst_data");
    do_read(1, 32'h0, 1'b0, "rst_mask");
    do_read(2, 32'h0, 1'b0, "rst_edge");
    do_read(3, 32'h1, 1'b0, "rst_ctrl");
    idle(1);
    do_write(0, 32'h5);
    do_write(1, 32'hFFFF_FFFF);
    do_write(3, 32'hFFFF_FFFE);
    do_read(0, 32'h0, 1'b0, "data_ro");
    do_read(1, 32'h1FFFF, 1'b0, "mask_width");
    do_read(3, 32'h0, 1'b0, "ctrl_wr0");
    idle(2);

    // Mid-operation reset with bit 3 already high
    reset = 1'b1;
    in_port[3] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    do_read(1, 32'h0, 1'b0, "rst2_mask");
    do_read(3, 32'h1, 1'b0, "rst2_ctrl");
    do_read(2, 32'h0, 1'b0, "rst2_edge");
    idle(12);
    do_read(0, 32'h0, 1'b0, "deb_before");
    do_read(0, 32'h8, 1'b0, "deb_tick4");
    do_read(2, 32'h8, 1'b0, "edge_rise");
    idle(1);
    do_write(2, 32'h8);
    do_read(2, 32'h0, 1'b0, "edge_w1c");
    idle(1);
    do_write(1, 32'h8);
    do_read(1, 32'h8, 1'b0, "mask_8");
    idle(1);

    // Release: captured only when both edges are enabled
    in_port[3] = 1'b0;
    idle(40);
    do_read(0, 32'h0, REL_IRQ, "rel_data");
    do_read(2, REL_EDGE, REL_IRQ, "rel_edge");
    idle(1);
    do_write(2, 32'h8);
    do_read(2, 32'h0, 1'b0, "rel_clr");
    idle(1);

    // Bounce: two ticks high, two low, never accepted
    for (int i = 0; i < 6; i++) begin
      in_port[3] = ~in_port[3];
      idle(8);
    end
    do_read(0, 32'h0, 1'b0, "bounce_data");
    do_read(2, 32'h0, 1'b0, "bounce_edge");
    idle(1);
    in_port[3] = 1'b1;
    idle(40);
    do_read(0, 32'h8, 1'b1, "hold_data");
    do_read(2, 32'h8, 1'b1, "hold_edge");
    idle(1);
    do_write(2, 32'h8);
    do_read(2, 32'h0, 1'b0, "irq_clr");
    idle(1);

    // Bypass mode; W1C collides with a new rise on bit 3
    do_write(3, 32'h0);
    do_read(3, 32'h0, 1'b0, "bypass_ctrl");
    idle(1);
    in_port[3] = 1'b0;
    idle(5);
    do_write(2, 32'h8);
    do_read(2, 32'h0, 1'b0, "pre_coll");
    idle(1);
    in_port[3] = 1'b1;
    idle(3);
    do_write(2, 32'h8);
    do_read(2, 32'h8, 1'b1, "set_wins");
    idle(1);
    do_write(2, 32'h8);
    do_read(2, 32'h0, 1'b0, "coll_clr");
    idle(1);

    // Three-cycle pulse on bit 0 passes straight through
    in_port[0] = 1'b1;
    idle(3);
    in_port[0] = 1'b0;
    do_read(0, 32'h9, 1'b0, "byp_pulse");
    idle(6);
    do_read(0, 32'h8, 1'b0, "byp_after");
    do_read(2, 32'h1, 1'b0, "byp_edge");
    idle(1);
    do_write(1, 32'h1);
    do_read(1, 32'h1, 1'b1, "mask_1");
    idle(1);
    do_write(2, 32'h1);
    do_read(2, 32'h0, 1'b0, "final_clr");
    idle(3);

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
